// File: rtl/key_seq_pkg.sv
// key_seq_pkg: shared state encoding, default key words and counter widths for key_sequence_tx.
package key_seq_pkg;
    localparam int ST_W    = 3;
    localparam int WIN_W   = 3;
    localparam int RETRY_W = 2;
    localparam logic [4:0] KEY_CODE0     = 5'h10;
    localparam logic [4:0] KEY_CODE1     = 5'h0C;
    localparam logic [4:0] KEY_CODE2     = 5'h1D;
    localparam logic [4:0] KEY_IDLE_CODE = 5'h00;
    typedef enum logic [ST_W-1:0] {
        S_IDLE,
        S_SEND0,
        S_SEND1,
        S_SEND2,
        S_WAIT
`ifdef KEY_RETRY_EN
        , S_GAP
`endif
    } state_t;
endpackage

// File: rtl/key_seq_timer.sv
// key_seq_timer: loadable down-counter; done is high on the last cycle of the loaded window.
module key_seq_timer
    import key_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIN_W-1:0] value,
    output logic             done
);
    logic [WIN_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (en && count != '0) count <= count - 1'b1;
    end

    assign done = count <= WIN_W'(1);
endmodule

// File: rtl/key_sequence_tx.sv
// key_sequence_tx: sends a three-word key to the combination lock and reports pass/fail.
// Optional KEY_RETRY_EN adds up to MAX_RETRY extra attempts separated by one idle GAP cycle.
module key_sequence_tx
    import key_seq_pkg::*;
#(
    parameter logic [4:0]         CODE0     = KEY_CODE0,
    parameter logic [4:0]         CODE1     = KEY_CODE1,
    parameter logic [4:0]         CODE2     = KEY_CODE2,
    parameter logic [4:0]         IDLE_CODE = KEY_IDLE_CODE,
    parameter logic [WIN_W-1:0]   RESP_WAIT = 3'd2,
    parameter logic [RETRY_W-1:0] MAX_RETRY = 2'd3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic clk, rst, go, unlock, done;
    logic [4:0] code, code_n;
    logic busy, busy_n, pass, pass_n, fail, fail_n;
    state_t state, state_n;
    logic unused_pins;

    assign rst         = io_in[1];
    assign clk         = io_in[2];
    assign go          = io_in[3];
    assign unlock      = io_in[4];
    assign unused_pins = ^{io_in[0], io_in[7:5]};
    assign io_out      = {fail, pass, busy, code};

`ifdef KEY_RETRY_EN
    logic [RETRY_W-1:0] retry, retry_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retry <= '0;
        else retry <= retry_n;
    end
`else
    localparam logic [RETRY_W-1:0] unused_max_retry = MAX_RETRY;
`endif

    key_seq_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_SEND2),
        .en   (state == S_WAIT),
        .value(RESP_WAIT),
        .done (done)
    );

    always_comb begin
        state_n = state;
        busy_n  = busy;
        pass_n  = pass;
        fail_n  = fail;
`ifdef KEY_RETRY_EN
        retry_n = retry;
`endif
        case (state)
            S_IDLE: if (go) begin
                state_n = S_SEND0;
                busy_n  = 1'b1;
                pass_n  = 1'b0;
                fail_n  = 1'b0;
`ifdef KEY_RETRY_EN
                retry_n = '0;
`endif
            end
            S_SEND0: state_n = S_SEND1;
            S_SEND1: state_n = S_SEND2;
            S_SEND2: state_n = S_WAIT;
            S_WAIT: if (unlock) begin
                state_n = S_IDLE;
                pass_n  = 1'b1;
                busy_n  = 1'b0;
            end else if (done) begin
`ifdef KEY_RETRY_EN
                if (retry < MAX_RETRY) begin
                    state_n = S_GAP;
                    retry_n = retry + 1'b1;
                end else begin
                    state_n = S_IDLE;
                    fail_n  = 1'b1;
                    busy_n  = 1'b0;
                end
`else
                state_n = S_IDLE;
                fail_n  = 1'b1;
                busy_n  = 1'b0;
`endif
            end
`ifdef KEY_RETRY_EN
            S_GAP: state_n = S_SEND0;
`endif
            default: state_n = S_IDLE;
        endcase
        // code is registered from the next state so it lines up with the state it belongs to
        code_n = state_n == S_SEND0 ? CODE0 :
                 state_n == S_SEND1 ? CODE1 :
                 state_n == S_SEND2 ? CODE2 : IDLE_CODE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            code  <= IDLE_CODE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= state_n;
            code  <= code_n;
            busy  <= busy_n;
            pass  <= pass_n;
            fail  <= fail_n;
        end
    end
endmodule

// File: tb/tb_key_sequence_tx.sv
// tb_key_sequence_tx: loopback of key_sequence_tx to a behavioural lock, scoreboard-checked per cycle.
module tb_key_sequence_tx;
    typedef struct {
        logic [7:0] v;
        string      n;
    } exp_t;

    logic clk = 0, rst = 1, go = 0, frc = 0;
    logic [4:0] lk0 = 5'h10, lk1 = 5'h0C, lk2 = 5'h1D;
    logic [1:0] lst;
    logic lock_unlock;
    logic [7:0] io_in, io_out;
    exp_t sb[$];
    int checks = 0, errors = 0;

`ifdef KEY_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    always #5 clk = ~clk;

    assign lock_unlock = lst == 2'd3;
    assign io_in = {3'b000, frc | lock_unlock, go, clk, rst, 1'b0};

    key_sequence_tx #(.MAX_RETRY(2'd2)) dut (.io_in(io_in), .io_out(io_out));

    // lock model: advances on each matching word, any other word restarts the match
    always @(posedge clk or posedge rst) begin
        if (rst) lst <= 2'd0;
        else if (io_out[4:0] == lk0) lst <= 2'd1;
        else if (lst == 2'd1 && io_out[4:0] == lk1) lst <= 2'd2;
        else if (lst == 2'd2 && io_out[4:0] == lk2) lst <= 2'd3;
        else lst <= 2'd0;
    end

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.n, io_out, e.v);
        end
    end

    function automatic logic [7:0] ev(logic [4:0] c, logic b, logic p, logic f);
        return {f, p, b, c};
    endfunction

    task automatic step(input logic g, input logic fv, input logic [7:0] e, input string n);
        @(negedge clk);
        go  = g;
        frc = fv;
        sb.push_back('{e, n});
    endtask

    task automatic run_good(input logic hold, input string n);
        step(1, 0, ev(5'h10, 1, 0, 0), n);
        step(hold, 0, ev(5'h0C, 1, 0, 0), n);
        step(hold, 0, ev(5'h1D, 1, 0, 0), n);
        step(hold, 0, ev(5'h00, 1, 0, 0), n);
        step(hold, 0, ev(5'h00, 0, 1, 0), n);
    endtask

    task automatic run_wrong(input logic fv, input string n);
        for (int a = 0; a < ATTEMPTS; a++) begin
            logic f1;
            f1 = fv && a == 0;
            step(a == 0, f1, ev(5'h10, 1, 0, 0), n);
            step(0, f1, ev(5'h0C, 1, 0, 0), n);
            step(0, f1, ev(5'h1D, 1, 0, 0), n);
            step(0, f1, ev(5'h00, 1, 0, 0), n);
            step(0, 0, ev(5'h00, 1, 0, 0), n);
            step(0, 0, a < ATTEMPTS - 1 ? ev(5'h00, 1, 0, 0) : ev(5'h00, 0, 0, 1), n);
        end
    endtask

    initial begin
        #1;
        chk("reset_state", io_out, 8'h00);
        repeat (2) @(negedge clk);
        rst = 0;
        run_good(0, "good_key");
        step(0, 0, ev(5'h00, 0, 1, 0), "good_idle");
        lk0 = 5'h11;
        run_wrong(0, "wrong_key");
        step(0, 0, ev(5'h00, 0, 0, 1), "wrong_idle");
        step(0, 1, ev(5'h00, 0, 0, 1), "spurious_idle");
        run_wrong(1, "spurious_send");
        step(0, 0, ev(5'h00, 0, 0, 1), "spurious_done");
        lk0 = 5'h10;
        run_good(1, "held_go_first");
        run_good(0, "held_go_second");
        step(0, 0, ev(5'h00, 0, 1, 0), "held_go_idle");
        step(1, 0, ev(5'h10, 1, 0, 0), "rst_burst");
        step(0, 0, ev(5'h0C, 1, 0, 0), "rst_burst");
        @(negedge clk);
        rst = 1;
        #1;
        chk("async_reset", io_out, 8'h00);
        step(0, 0, 8'h00, "reset_hold");
        step(0, 0, 8'h00, "reset_hold");
        @(negedge clk);
        rst = 0;
        run_good(0, "after_reset");
        step(0, 0, ev(5'h00, 0, 1, 0), "after_reset_idle");
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
